dmem_wait: RTL
==============

DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 Parameter DEPTH, default 64, is the number of 32-bit words; it SHALL be a power of two and at least 4.
REQ-002 Parameter LATENCY, default 2, is the number of wait cycles between request acceptance and response; it SHALL allow 0..15.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1 bit: a request is presented.
REQ-006 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 Port req_size, input, 3 bits: RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-008 Port req_addr, input, 32 bits: byte address.
REQ-009 Port req_wdata, input, 32 bits: store data, taken from the low bits for b and h.
REQ-010 Port busy, output, 1 bit: high from acceptance until the response cycle, inclusive.
REQ-011 Port resp_valid, output, 1 bit: single-cycle response pulse.
REQ-012 Port resp_rdata, output, 32 bits: load result, extended as required; 0 for stores and errors.
REQ-013 Port resp_err, output, 1 bit: misaligned access or unsupported req_size; valid only while resp_valid is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req_valid=1, the block SHALL latch we/size/addr/wdata and go to WAIT, or to RESP when LATENCY=0.
REQ-016 Input changes after acceptance SHALL be ignored.
REQ-017 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-018 Acceptance-to-resp_valid latency SHALL be LATENCY+1 cycles.
REQ-019 RESP SHALL last exactly one cycle and SHALL always return to IDLE; req_valid during RESP is not accepted.
REQ-020 The requester SHALL hold req_valid until resp_valid. A still-high req_valid in the following IDLE cycle is a new request.
REQ-021 A store SHALL be committed on the clock edge that enters RESP.
REQ-022 Store byte enables: b writes lane addr[1:0]; h writes lanes {addr[1],0} and {addr[1],1}; w writes all lanes.
REQ-023 A load SHALL read combinationally in RESP from the word addressed by addr[log2(DEPTH)+1:2].
REQ-024 Load extraction: b/h sign-extend and bu/hu zero-extend the lane selected by addr[1:0]; w passes the word unchanged.
REQ-025 Addresses beyond DEPTH words SHALL wrap, since upper address bits are ignored.
REQ-026 Misalignment is defined as h/hu with addr[0]=1, or w with addr[1:0]!=0.
REQ-027 A misaligned access or an unsupported size SHALL set resp_err=1 and resp_rdata=0, and SHALL leave memory unmodified.
REQ-028 Outputs SHALL be registered or decoded from state only, with no combinational path from req_* to busy or resp_valid.

Reset
REQ-029 While reset_n=0, the FSM SHALL be in IDLE, the counter and latched request SHALL be 0, and busy, resp_valid, resp_err and resp_rdata SHALL be 0.
REQ-030 Reset asserted during WAIT SHALL abort the request, and the pending store SHALL never be committed.
REQ-031 Reset SHALL not clear memory contents; their power-up contents are undefined.
REQ-032 The first acceptance after reset deassertion SHALL occur no earlier than the first rising edge with reset_n=1.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the state enum.
REQ-034 A sub-module lsu_align SHALL be purely combinational.
REQ-035 Its inputs SHALL be size, addr[1:0], wdata and the raw read word.
REQ-036 Its outputs SHALL be byte enables, shifted store data, extended load data and the misalign flag.

Verification
REQ-037 LATENCY=2: sw 0x12345678 to addr 100, then lw from 100 -> resp_valid exactly 3 cycles after each acceptance, rdata 0x12345678.
REQ-038 After word 0x12345678 at 100: sb 0xAB to 101, then lw 100 -> 0x1234AB78; lb 101 -> 0xFFFFFFAB; lbu 101 -> 0x000000AB.
REQ-039 sh 0x8001 to 102, then lh 102 -> 0xFFFF8001; lhu 102 -> 0x00008001; lw 102 -> resp_err=1, rdata 0, memory unchanged.
REQ-040 reset_n pulsed low in WAIT of sw 0xDEADBEEF to 96 (word previously 0x0) -> resp_valid never pulses, busy=0, and a subsequent lw 96 returns 0x0.
REQ-041 LATENCY=0, DEPTH=64: sw 25 to addr 356 (wraps to 100), then lw 100 -> 25, resp_valid 1 cycle after each acceptance.
REQ-042 req_valid held high across two back-to-back requests -> exactly one IDLE cycle between the two resp_valid pulses, with no double commit.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory: RV32I load/store sizes and FSM states.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic size_ok(input logic [2:0] sz);
    logic ok;
    case (sz)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_wait_lsu_align.sv
// Combinational lane steering: store byte enables and replicated data, load extraction
// with sign/zero extension, and the misalignment flag.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = 8'(rword >> {addr_lo, 3'b000});
    half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
    be        = 4'b0000;
    wdata_sh  = 32'h0;
    rdata_ext = 32'h0;
    misalign  = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      SZ_H, SZ_HU: begin
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = (size == SZ_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      SZ_W: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_wait.sv
// Single-port data memory with a fixed number of wait cycles per access; one request at a time.
//
//  state | meaning
//  IDLE  | ready; req_valid is accepted and latched on the next edge
//  WAIT  | down-counter running toward the response
//  RESP  | one-cycle response; load data decoded from the latched request
module dmem_wait
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      size_q, size_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [31:0]     mem [DEPTH];

  logic            src_we;
  logic [2:0]      src_size;
  logic [AW+1:0]   src_addr;
  logic [31:0]     src_wdata;
  logic            src_err, enter_resp, mem_we, misalign;
  logic [3:0]      be;
  logic [31:0]     wdata_sh, rword, rdata_ext;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  // With LATENCY=0 the commit edge is the acceptance edge, so the live request feeds the aligner in IDLE.
  always_comb begin
    src_we    = we_q;
    src_size  = size_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    if (state_q == IDLE) begin
      src_we    = req_we;
      src_size  = req_size;
      src_addr  = req_addr[AW+1:0];
      src_wdata = req_wdata;
    end
  end

  assign rword = mem[src_addr[AW+1:2]];

  lsu_align u_align (
    .size      (src_size),
    .addr_lo   (src_addr[1:0]),
    .wdata     (src_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign src_err = misalign | ~size_ok(src_size);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // reset_n gates the write so a request racing reset can never land in memory.
  assign mem_we = enter_resp & src_we & ~src_err & reset_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[src_addr[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & src_err;
  assign resp_rdata = (resp_valid & ~we_q & ~src_err) ? rdata_ext : 32'h0;

endmodule
